mavg_channel_arbiter: RTL

//   Round-robin scheduler that shares one moving-average filter engine between
//   N_CH sample requesters, e.g. the X/Y/Z accelerometer axes.
//   - Accepts one 8-bit sample at a time, issues it to the engine with its channel id,

---
 rtl/mavg_channel_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mavg_channel_arbiter.sv
// rtl/mavg_channel_arbiter.sv - round-robin scheduler sharing one moving-average engine
// between N_CH sample requesters, with an engine-hang timeout and sticky error flag.
module mavg_channel_arbiter #(
  parameter int N_CH    = 3,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 600,
  parameter int TO_W    = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_CH-1:0]   req_valid_i,
  input  logic [N_CH*8-1:0] req_data_i,
  output logic [N_CH-1:0]   req_ready_o,
  output logic              eng_start_o,
  output logic [CH_W-1:0]   eng_ch_o,
  output logic [7:0]        eng_data_o,
  input  logic              eng_done_i,
  input  logic [7:0]        eng_result_i,
  output logic [N_CH-1:0]   res_valid_o,
  output logic [N_CH*8-1:0] res_data_o,
  output logic              timeout_err_o,
  output logic [CH_W-1:0]   err_ch_o,
  input  logic              timeout_clr_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [7:0]        data_q, data_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [N_CH*8-1:0] res_data_q, res_data_d;
  logic              err_q, err_d;
  logic [CH_W-1:0]   err_ch_q, err_ch_d;

  logic [N_CH-1:0]   rot_req;
  logic              gnt_any;
  logic [CH_W-1:0]   gnt_ch;
  logic [7:0]        gnt_data;
  logic              to_hit;

  // Rotate so bit 0 is the channel just after rr_ptr; lowest set bit wins.
  always_comb begin
    rot_req = N_CH'({req_valid_i, req_valid_i} >> (int'(rr_ptr_q) + 1));
    gnt_any = 1'b0;
    gnt_ch  = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (rot_req[j]) begin
        gnt_any = 1'b1;
        gnt_ch  = CH_W'((int'(rr_ptr_q) + 1 + j) % N_CH);
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_ch == CH_W'(k)) gnt_data = req_data_i[8*k +: 8];
    end
  end

  assign to_hit = (state_q == S_WAIT) && !eng_done_i && (cnt_q == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (gnt_any) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done_i)  state_d = S_WB;
        else if (to_hit) state_d = S_IDLE;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    eng_start_o = 1'b0;
    res_valid_o = '0;
    unique case (state_q)
      S_IDLE:  if (gnt_any) req_ready_o = N_CH'(1) << gnt_ch;
      S_ISSUE: eng_start_o = 1'b1;
      S_WB:    res_valid_o = N_CH'(1) << ch_q;
      default: ;
    endcase
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    ch_d       = ch_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    err_d      = err_q;
    err_ch_d   = err_ch_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          ch_d   = gnt_ch;
          data_d = gnt_data;
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        if (cnt_q != TO_MAX) cnt_d = cnt_q + TO_W'(1);
        // Slot is loaded on the answer so it is already valid while res_valid pulses.
        if (eng_done_i) begin
          for (int k = 0; k < N_CH; k++) begin
            if (ch_q == CH_W'(k)) res_data_d[8*k +: 8] = eng_result_i;
          end
        end else if (to_hit) begin
          rr_ptr_d = ch_q;
        end
      end
      S_WB:    rr_ptr_d = ch_q;
      default: ;
    endcase
    if (timeout_clr_i) begin
      err_d    = 1'b0;
      err_ch_d = '0;
    end else if (to_hit) begin
      err_d    = 1'b1;
      err_ch_d = ch_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= CH_LAST;
      ch_q       <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
      err_ch_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      ch_q       <= ch_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
      err_ch_q   <= err_ch_d;
    end
  end

  assign eng_ch_o      = ch_q;
  assign eng_data_o    = data_q;
  assign res_data_o    = res_data_q;
  assign timeout_err_o = err_q;
  assign err_ch_o      = err_ch_q;

endmodule
